// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//
// Hazard and stall controller for the five-stage pipeline. It drives the
// load/hold/flush/bubble controls of the PC, IF/ID, ID/EX and EX/MEM
// registers. Three hazards are handled:
//   - load-use hazards detected in ID
//   - taken branches/jumps resolved in EX
//   - multi-cycle multiplies occupying EX
// Saturating stall and flush counters are kept for performance debug.
//
// Ports
//   clk              pipeline clock; all state updates on the rising edge
//   Reset            synchronous, active-high reset
//   IFIDRsIn/RtIn    rs/rt fields of the instruction in ID
//   UsesRsIn/RtIn    the ID instruction reads rs/rt
//   IDEXMemReadIn    the instruction in EX is a load
//   IDEXRtIn         destination (rt) of the instruction in EX
//   MulEXIn          the instruction in EX is a multiply
//   BranchTakenEXIn  branch/jump in EX resolved taken this cycle
//   PCWriteOut       PC load enable
//   IFIDWriteOut     IF/ID load enable
//   IFIDFlushOut     IF/ID clears to NOP on the next edge
//   IDEXBubbleOut    ID/EX loads zeroed control fields on the next edge
//   IDEXHoldOut      ID/EX keeps its current contents
//   EXMEMBubbleOut   EX/MEM loads zeroed control fields
//   StallCountOut    saturating count of cycles with PCWriteOut=0
//   FlushCountOut    saturating count of taken-branch flush cycles
//   DbgStateOut      current FSM state (RUN=0, MUL_BUSY=1, DRAIN=2)
//
// Handshake: there is no valid/ready pairing. Every control output is a
// combinational decision for the current cycle. The pipeline registers act
// on it at the next rising edge, and nothing is acknowledged back.

module pipeline_hazard_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [4:0]       IFIDRsIn,
  input  logic [4:0]       IFIDRtIn,
  input  logic             UsesRsIn,
  input  logic             UsesRtIn,
  input  logic             IDEXMemReadIn,
  input  logic [4:0]       IDEXRtIn,
  input  logic             MulEXIn,
  input  logic             BranchTakenEXIn,
  output logic             PCWriteOut,
  output logic             IFIDWriteOut,
  output logic             IFIDFlushOut,
  output logic             IDEXBubbleOut,
  output logic             IDEXHoldOut,
  output logic             EXMEMBubbleOut,
  output logic [CNT_W-1:0] StallCountOut,
  output logic [CNT_W-1:0] FlushCountOut,
  output logic [1:0]       DbgStateOut
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MUL_BUSY = 2'd1,
    S_DRAIN    = 2'd2
  } state_t;

  // Holds counted in the RUN detect cycle come off the MUL_BUSY budget.
  localparam logic [3:0] MUL_BUSY_CYCLES = 4'(MUL_LATENCY - 2);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_load_use;

  // A destination of register 0 is never a real dependency.
  assign w_load_use = IDEXMemReadIn && (IDEXRtIn != 5'd0) &&
                      ((UsesRsIn && (IFIDRsIn == IDEXRtIn)) ||
                       (UsesRtIn && (IFIDRtIn == IDEXRtIn)));

  always_comb begin
    PCWriteOut     = 1'b1;
    IFIDWriteOut   = 1'b1;
    IFIDFlushOut   = 1'b0;
    IDEXBubbleOut  = 1'b0;
    IDEXHoldOut    = 1'b0;
    EXMEMBubbleOut = 1'b0;
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;

    if (Reset) begin
      PCWriteOut     = 1'b0;
      IFIDWriteOut   = 1'b0;
      IFIDFlushOut   = 1'b1;
      IDEXBubbleOut  = 1'b1;
      EXMEMBubbleOut = 1'b1;
      w_state_nxt    = S_RUN;
      w_cnt_nxt      = 4'd0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (MulEXIn) begin
            PCWriteOut     = 1'b0;
            IFIDWriteOut   = 1'b0;
            IDEXHoldOut    = 1'b1;
            EXMEMBubbleOut = 1'b1;
            w_cnt_nxt      = MUL_BUSY_CYCLES;
            w_state_nxt    = (MUL_LATENCY == 2) ? S_DRAIN : S_MUL_BUSY;
          end else if (BranchTakenEXIn) begin
            IFIDFlushOut  = 1'b1;
            IDEXBubbleOut = 1'b1;
          end else if (w_load_use) begin
            PCWriteOut    = 1'b0;
            IFIDWriteOut  = 1'b0;
            IDEXBubbleOut = 1'b1;
          end
        end
        S_MUL_BUSY: begin
          // Multiply owns EX; branch and load-use are not looked at.
          PCWriteOut     = 1'b0;
          IFIDWriteOut   = 1'b0;
          IDEXHoldOut    = 1'b1;
          EXMEMBubbleOut = 1'b1;
          w_cnt_nxt      = r_cnt - 4'd1;
          if (r_cnt == 4'd1) w_state_nxt = S_DRAIN;
        end
        S_DRAIN: begin
          // MulEXIn still reflects the finishing multiply, so it is ignored.
          if (BranchTakenEXIn) begin
            IFIDFlushOut  = 1'b1;
            IDEXBubbleOut = 1'b1;
          end else if (w_load_use) begin
            PCWriteOut    = 1'b0;
            IFIDWriteOut  = 1'b0;
            IDEXBubbleOut = 1'b1;
          end
          w_state_nxt = S_RUN;
        end
        default: begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state     <= S_RUN;
      r_cnt       <= 4'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (!PCWriteOut && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (IFIDFlushOut && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign StallCountOut = r_stall_cnt;
  assign FlushCountOut = r_flush_cnt;
  assign DbgStateOut   = r_state;

endmodule
